door_direction_detector: RTL

Producer side of the room-lighting `entering` interface: turns two raw infrared beam-break sensors mounted across a doorway into clean one-cycle `entering` and `leaving` pulses. It also keeps a saturating occupancy count, so `entering`/`occupied` can drive the automatic light controller directly. Each sensor input is synchronised and debounced, then a direction-decoding FSM checks the beam-break order and supervises it with a timeout.

---
 rtl/door_direction_detector_if.sv | 23 ++
 rtl/door_direction_detector.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/door_direction_detector_if.sv
// Doorway sensor/pulse bundle: raw beam inputs in, passage pulses and occupancy out.
// The detector takes the master modport and drives the outputs; consumers use slave.
interface door_direction_detector_if #(
  parameter int CNT_W = 4
);
  logic             beam_out;
  logic             beam_in;
  logic             entering;
  logic             leaving;
  logic             fault;
  logic [CNT_W-1:0] count;
  logic             occupied;

  modport master (
    input  beam_out, beam_in,
    output entering, leaving, fault, count, occupied
  );

  modport slave (
    output beam_out, beam_in,
    input  entering, leaving, fault, count, occupied
  );
endinterface

// File: rtl/door_direction_detector.sv
// Two-beam doorway direction detector: sync + debounce per beam, order-checking FSM
// with dwell timeout, and a saturating occupancy counter driven by the passage pulses.
module door_direction_detector #(
  parameter int DEBOUNCE = 4,
  parameter int TIMEOUT  = 1000,
  parameter int CNT_W    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  door_direction_detector_if.master  dif
);
  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_E1, S_E2, S_E3, S_L1, S_L2, S_L3, S_ABORT, S_FAULT
  } state_t;

  logic [1:0] raw;
  logic [1:0] filt;  // bit 1 = outer beam, bit 0 = inner beam

  assign raw = {dif.beam_out, dif.beam_in};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_beam
      logic            sync1_q, sync2_q, filt_q, filt_d;
      logic [DB_W-1:0] db_cnt_q, db_cnt_d;

      always_comb begin
        filt_d   = filt_q;
        db_cnt_d = '0;
        if (sync2_q != filt_q) begin
          if (db_cnt_q == DB_W'(DEBOUNCE - 1)) filt_d = sync2_q;
          else                                 db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1_q  <= 1'b0;
          sync2_q  <= 1'b0;
          filt_q   <= 1'b0;
          db_cnt_q <= '0;
        end else begin
          sync1_q  <= raw[gi];
          sync2_q  <= sync1_q;
          filt_q   <= filt_d;
          db_cnt_q <= db_cnt_d;
        end
      end

      assign filt[gi] = filt_q;
    end
  endgenerate

  state_t           state_q, state_d;
  logic [TO_W-1:0]  dwell_q, dwell_d;
  logic             entering_q, entering_d;
  logic             leaving_q, leaving_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    state_d    = state_q;
    entering_d = 1'b0;
    leaving_d  = 1'b0;
    case (state_q)
      S_IDLE: case (filt)
        2'b10:   state_d = S_E1;
        2'b01:   state_d = S_L1;
        2'b11:   state_d = S_ABORT;
        default: state_d = S_IDLE;
      endcase
      S_E1: case (filt)
        2'b10:   state_d = S_E1;
        2'b11:   state_d = S_E2;
        2'b00:   state_d = S_IDLE;
        default: state_d = S_ABORT;
      endcase
      S_E2: case (filt)
        2'b11:   state_d = S_E2;
        2'b01:   state_d = S_E3;
        2'b10:   state_d = S_E1;
        default: state_d = S_IDLE;
      endcase
      S_E3: case (filt)
        2'b01:   state_d = S_E3;
        2'b11:   state_d = S_E2;
        2'b00: begin
          state_d    = S_IDLE;
          entering_d = 1'b1;
        end
        default: state_d = S_ABORT;
      endcase
      S_L1: case (filt)
        2'b01:   state_d = S_L1;
        2'b11:   state_d = S_L2;
        2'b00:   state_d = S_IDLE;
        default: state_d = S_ABORT;
      endcase
      S_L2: case (filt)
        2'b11:   state_d = S_L2;
        2'b10:   state_d = S_L3;
        2'b01:   state_d = S_L1;
        default: state_d = S_IDLE;
      endcase
      S_L3: case (filt)
        2'b10:   state_d = S_L3;
        2'b11:   state_d = S_L2;
        2'b00: begin
          state_d   = S_IDLE;
          leaving_d = 1'b1;
        end
        default: state_d = S_ABORT;
      endcase
      S_ABORT, S_FAULT: state_d = (filt == 2'b00) ? S_IDLE : state_q;
      default:          state_d = S_IDLE;
    endcase

    // A real transition always wins over the timeout on the same edge.
    dwell_d = '0;
    if (state_d == state_q && state_q != S_IDLE && state_q != S_FAULT) begin
      if (dwell_q == TO_W'(TIMEOUT - 1)) state_d = S_FAULT;
      else                               dwell_d = dwell_q + 1'b1;
    end
    fault_d = (state_d == S_FAULT);

    count_d = count_q;
    if (entering_q && count_q != '1)       count_d = count_q + 1'b1;
    else if (leaving_q && count_q != '0)   count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dwell_q    <= '0;
      entering_q <= 1'b0;
      leaving_q  <= 1'b0;
      fault_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      entering_q <= entering_d;
      leaving_q  <= leaving_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
    end
  end

  assign dif.entering = entering_q;
  assign dif.leaving  = leaving_q;
  assign dif.fault    = fault_q;
  assign dif.count    = count_q;
  assign dif.occupied = (count_q != '0);
endmodule
